rcvfifo: RTL
============

# rcvfifo

Parametrised serial-line receiver with an integrated receive FIFO, successor to the single-character receiver buffer. It deserialises asynchronous start/stop frames with configurable data width and optional parity, checks framing and parity per character, and queues up to DEPTH characters with per-entry error flags. A sticky overrun flag records every dropped character. It sits between the serial_in pin and the serial-line register interface.

## Interface
- DATA_BITS, 8: data bits per frame, 5..8, LSB first.
- DEPTH, 16: FIFO entries, power of two, >= 2.
- CW, $clog2(DEPTH+1): width of count.

- clk  in  1  system clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- bit_len  in  16  clocks per bit, >= 4; sampled at each start-bit detection.
- parity_en  in  1  1 = frame carries a parity bit after the data.
- parity_odd  in  1  1 = odd parity, 0 = even; used only when parity_en = 1.
- read  in  1  pop head entry; ignored when ready = 0.
- clr_err  in  1  clear sticky overrun.
- ready  out  1  FIFO not empty.
- data_out  out  DATA_BITS  head-entry data, first-word fall-through; valid when ready = 1.
- frame_err  out  1  head entry had a low stop bit.
- parity_err  out  1  head entry failed the parity check.
- overrun  out  1  sticky: at least one character dropped because the FIFO was full.
- count  out  CW  entries held, 0..DEPTH.
- serial_in  in  1  asynchronous line, idles high.

## Operation
- serial_in passes through a 2-flop synchroniser, reset to 1.
- Receiver FSM states: IDLE, START, DATA, PARITY, STOP, BREAK. A bit counter counts down from the loaded period and a bit index counts 0..DATA_BITS-1.
- IDLE: a synchronised high-to-low transition latches bit_len and loads the counter with bit_len>>1 -> START.
- START: on counter expiry, sample the line. If high, it is a false start -> IDLE. If low, load bit_len -> DATA.
- DATA: each expiry shifts the sample in LSB first and reloads bit_len. After DATA_BITS samples -> PARITY if parity_en, otherwise -> STOP.
- PARITY: on expiry, compute p_err = XOR(data, sample) XOR parity_odd; the result is 1 on mismatch. Then -> STOP. p_err = 0 when parity is disabled.
- STOP: on expiry, sample the stop bit; f_err = ~sample. Push {f_err, p_err, data} into the FIFO on this same cycle. Go to IDLE if the sample is 1, otherwise to BREAK.
- BREAK: wait for the synchronised line to read 1 -> IDLE. This prevents re-triggering on a held-low line.
- parity_en and parity_odd are sampled at the start-bit detection and held for the whole frame.
- Push while count = DEPTH with no read in the same cycle: the character is discarded, FIFO contents are unchanged, and overrun is set.
- Push and read in the same cycle while full: the pop happens first and the push succeeds. count stays DEPTH and no overrun is flagged.
- Push and read in the same cycle when 0 < count < DEPTH: count is unchanged.
- Read while empty: no effect. count never underflows.
- clr_err and an overrun event in the same cycle: overrun stays 1 (set wins).
- Pointers are log2(DEPTH) bits and wrap naturally. Fullness comes from count, not pointer equality.

## Timing
- Reset values: ready = 0, count = 0, overrun = 0, frame_err = 0, parity_err = 0, data_out = 0, FSM = IDLE, synchroniser = 1, pointers = 0.
- rst asserted mid-frame aborts the frame. The partial character is never pushed and the FIFO is emptied.
- Start detection occurs 2 clocks after the serial_in falling edge (synchroniser delay). Each sample is taken at bit centre ± 1 clock.
- ready, count, data_out, frame_err and parity_err update on the clock edge after the push or pop. The push itself happens on the stop-sample cycle.
- After a read is accepted, the next entry appears on data_out in the following cycle. Back-to-back reads on consecutive cycles are allowed.
- overrun rises on the clock edge after the dropped push.

## Test plan
- bit_len = 16, no parity: send 0xA5 with a good stop bit -> ready = 1, data_out = 0xA5, errors = 0, count = 1. Pulse read -> ready = 0, count = 0.
- parity_en = 1, parity_odd = 0: send 0x07 with parity bit 1, then 0x07 with parity bit 0 -> first entry parity_err = 0, second entry parity_err = 1.
- Stop bit low, then line held low for 5 bit times, then idle -> exactly one entry, 0x00 with frame_err = 1. No further pushes occur until the line returns high.
- DEPTH = 4: send 5 characters with no reads -> count = 4, overrun = 1, the first 4 characters are read out in order. clr_err -> overrun = 0.
- FIFO full and read asserted on the stop-sample cycle of a 5th character -> count stays 4, overrun = 0, 5th character is at the tail.
- A 0.25-bit low glitch on serial_in -> false start, no push. Separately, assert rst mid-DATA -> count = 0, next clean frame is received correctly.

Source files
------------

// File: rtl/rcvfifo.sv
// Serial-line receiver: start/stop deserialiser with optional parity feeding a
// first-word-fall-through FIFO that carries per-entry frame/parity error flags.
module rcvfifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16,
  parameter int CW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          bit_len,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 read,
  input  logic                 clr_err,
  output logic                 ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic [CW-1:0]        count,
  input  logic                 serial_in
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_BITS + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t               state;
  logic                 sync1, sync2, line_prev;
  logic [15:0]          blen, cnt;
  logic [2:0]           idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_en, par_odd, p_err;
  logic                 expire, push;
  logic [EW-1:0]        push_word;

  always_comb begin
    expire    = (cnt <= 16'd1);
    push      = (state == STOP) && expire;
    push_word = {~sync2, p_err, shreg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      line_prev <= 1'b1;
      state     <= IDLE;
      blen      <= '0;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      par_en    <= 1'b0;
      par_odd   <= 1'b0;
      p_err     <= 1'b0;
    end else begin
      sync1     <= serial_in;
      sync2     <= sync1;
      line_prev <= sync2;
      if (state != IDLE && !expire)
        cnt <= cnt - 16'd1;
      case (state)
        IDLE: begin
          if (line_prev && !sync2) begin
            blen    <= bit_len;
            cnt     <= bit_len >> 1;
            par_en  <= parity_en;
            par_odd <= parity_odd;
            idx     <= '0;
            p_err   <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (expire) begin
            if (sync2) begin
              state <= IDLE;
            end else begin
              cnt   <= blen;
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (expire) begin
            shreg <= {sync2, shreg[DATA_BITS-1:1]};
            cnt   <= blen;
            idx   <= idx + 3'd1;
            if (idx == 3'(DATA_BITS - 1))
              state <= par_en ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (expire) begin
            p_err <= (^shreg) ^ sync2 ^ par_odd;
            cnt   <= blen;
            state <= STOP;
          end
        end
        STOP: begin
          if (expire)
            state <= sync2 ? IDLE : BREAK;
        end
        BREAK: begin
          if (sync2)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          pop, full, wr;
  logic [EW-1:0] head;

  always_comb begin
    pop  = read && (count != '0);
    full = (count == CW'(DEPTH));
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    wr   = push && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem[wptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      if (wr && !pop)
        count <= count + 1'b1;
      else if (!wr && pop)
        count <= count - 1'b1;
      if (push && full && !pop)
        overrun <= 1'b1;
      else if (clr_err)
        overrun <= 1'b0;
    end
  end

  // Head fields are gated by ready so the outputs read zero whenever the FIFO is empty.
  always_comb begin
    head       = mem[rptr];
    ready      = (count != '0);
    data_out   = ready ? head[DATA_BITS-1:0] : '0;
    parity_err = ready && head[DATA_BITS];
    frame_err  = ready && head[DATA_BITS+1];
  end

endmodule
